// File: rtl/cnt_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cnt_pkg
// Brief    : Shared defaults and direction encoding for the modulo up/down
//            counter and its callers.
// Revision : 1.0 - initial release
// ============================================================================
package cnt_pkg;

  // Defaults reproduce the legacy 4-bit, modulo-16 counter.
  localparam int CNT_WIDTH_DEF = 4;
  localparam int CNT_MAX_DEF   = 15;

  // Count direction as driven on the 'up' input.
  typedef enum logic {
    CNT_DOWN = 1'b0,
    CNT_UP   = 1'b1
  } cnt_dir_e;

endpackage : cnt_pkg
`default_nettype wire

// File: rtl/mod_updown_counter.sv
`default_nettype none
// ============================================================================
// Module   : mod_updown_counter
// Brief    : Parametrised modulo up/down counter with synchronous load,
//            count enable, wrap/saturate mode and registered status flags.
//            All outputs lag the internal count by one clock.
// Revision : 1.0 - initial release
// ============================================================================
module mod_updown_counter
  import cnt_pkg::*;
#(
  parameter int WIDTH   = CNT_WIDTH_DEF,
  parameter int MAX_VAL = CNT_MAX_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up,
  input  logic             sat_mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] number,
  output logic             zero,
  output logic             tc,
  output logic             wrap
);

  // Terminal count at the counter's own width.
  localparam logic [WIDTH-1:0] C_MAX  = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] C_ZERO = '0;
  localparam logic [WIDTH-1:0] C_ONE  = WIDTH'(1);

  // Elaboration-time legality check of the terminal count.
  if ((MAX_VAL < 1) ||
      (longint'(MAX_VAL) > ((longint'(1) << WIDTH) - longint'(1)))) begin : g_max_val_illegal
    $error("mod_updown_counter: MAX_VAL must lie in 1 .. 2**WIDTH-1");
  end

  // Internal count state and the wrap marker that travels with it.
  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;
  logic             wrap_q;
  logic             wrap_d;

  // Registered output stage.
  logic [WIDTH-1:0] number_q;
  logic             zero_q;
  logic             tc_q;
  logic             wrap_out_q;

  // Decoded direction and boundary conditions of the current count.
  cnt_dir_e         dir_w;
  logic             at_max_w;
  logic             at_zero_w;

  assign dir_w     = cnt_dir_e'(up);
  assign at_max_w  = (cnt_q == C_MAX);
  assign at_zero_w = (cnt_q == C_ZERO);

  // Next count: load beats counting; boundaries wrap or saturate explicitly
  // so the +1/-1 arithmetic never leaves the 0..MAX_VAL range.
  always_comb begin
    cnt_d  = cnt_q;
    wrap_d = 1'b0;
    if (load) begin
      cnt_d = (load_val > C_MAX) ? C_MAX : load_val;
    end else if (en) begin
      if (dir_w == CNT_UP) begin
        if (at_max_w) begin
          if (!sat_mode) begin
            cnt_d  = C_ZERO;
            wrap_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + C_ONE;
        end
      end else begin
        if (at_zero_w) begin
          if (!sat_mode) begin
            cnt_d  = C_MAX;
            wrap_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - C_ONE;
        end
      end
    end
  end

  // Count state register; asynchronous reset clears any partial operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= C_ZERO;
      wrap_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      wrap_q <= wrap_d;
    end
  end

  // Output stage: mirror the count and its flags one clock later. zero is
  // deliberately low out of reset and rises on the first edge afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      number_q   <= C_ZERO;
      zero_q     <= 1'b0;
      tc_q       <= 1'b0;
      wrap_out_q <= 1'b0;
    end else begin
      number_q   <= cnt_q;
      zero_q     <= at_zero_w;
      tc_q       <= at_max_w;
      wrap_out_q <= wrap_q;
    end
  end

  assign number = number_q;
  assign zero   = zero_q;
  assign tc     = tc_q;
  assign wrap   = wrap_out_q;

endmodule : mod_updown_counter
`default_nettype wire

// File: tb/tb_mod_updown_counter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mod_updown_counter
// Brief    : Self-checking bench for mod_updown_counter. Two instances
//            (MAX_VAL=15 and MAX_VAL=9) share one stimulus stream and are
//            compared every cycle against an arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mod_updown_counter;
  import cnt_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       up;
  logic       sat_mode;
  logic       load;
  logic [3:0] load_val;

  logic [3:0] num_a, num_b;
  logic       zero_a, zero_b, tc_a, tc_b, wrap_a, wrap_b;

  int total;
  int bad;

  // Reference model state, index 0 = MAX 15, index 1 = MAX 9.
  int maxv   [2];
  int m_cnt  [2];
  int m_wrap [2];
  int e_num  [2];
  int e_zero [2];
  int e_tc   [2];
  int e_wrap [2];
  int edge_n;

  mod_updown_counter #(.WIDTH(4), .MAX_VAL(15)) dut_a (
    .clk(clk), .rst_n(rst_n), .en(en), .up(up), .sat_mode(sat_mode),
    .load(load), .load_val(load_val),
    .number(num_a), .zero(zero_a), .tc(tc_a), .wrap(wrap_a)
  );

  mod_updown_counter #(.WIDTH(4), .MAX_VAL(9)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en), .up(up), .sat_mode(sat_mode),
    .load(load), .load_val(load_val),
    .number(num_b), .zero(zero_b), .tc(tc_b), .wrap(wrap_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_cnt[i]  = 0;
      m_wrap[i] = 0;
      e_num[i]  = 0;
      e_zero[i] = 0;
      e_tc[i]   = 0;
      e_wrap[i] = 0;
    end
    edge_n = 0;
  endtask

  // One clock of the specification: outputs show the old count, then the
  // count moves by load / +1 / -1 with wrap or saturation at the range ends.
  task automatic model_edge();
    int v;
    for (int i = 0; i < 2; i++) begin
      e_num[i]  = m_cnt[i];
      e_zero[i] = (m_cnt[i] == 0) ? 1 : 0;
      e_tc[i]   = (m_cnt[i] == maxv[i]) ? 1 : 0;
      e_wrap[i] = m_wrap[i];
      m_wrap[i] = 0;
      if (load) begin
        m_cnt[i] = (int'(load_val) > maxv[i]) ? maxv[i] : int'(load_val);
      end else if (en) begin
        v = up ? m_cnt[i] + 1 : m_cnt[i] - 1;
        if (v > maxv[i] || v < 0) begin
          if (!sat_mode) begin
            m_cnt[i]  = (v < 0) ? maxv[i] : 0;
            m_wrap[i] = 1;
          end
        end else begin
          m_cnt[i] = v;
        end
      end
    end
    edge_n++;
  endtask

  task automatic compare_all();
    chk("a.number", int'(num_a),  e_num[0]);
    chk("a.zero",   int'(zero_a), e_zero[0]);
    chk("a.tc",     int'(tc_a),   e_tc[0]);
    chk("a.wrap",   int'(wrap_a), e_wrap[0]);
    chk("b.number", int'(num_b),  e_num[1]);
    chk("b.zero",   int'(zero_b), e_zero[1]);
    chk("b.tc",     int'(tc_b),   e_tc[1]);
    chk("b.wrap",   int'(wrap_b), e_wrap[1]);
  endtask

  // Advance one clock and check every output against the model.
  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  task automatic drive(input logic e, input logic u, input logic s,
                       input logic l, input logic [3:0] lv);
    en = e; up = u; sat_mode = s; load = l; load_val = lv;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    maxv[0] = 15;
    maxv[1] = 9;
    model_reset();
    rst_n = 1'b0;
    drive(1'b0, CNT_UP, 1'b0, 1'b0, 4'd0);
    #12;
    chk("reset.number", int'(num_a), 0);
    chk("reset.zero",   int'(zero_a), 0);
    chk("reset.tc",     int'(tc_a), 0);
    chk("reset.wrap",   int'(wrap_a), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Legacy-style free-running up count.
    drive(1'b1, CNT_UP, 1'b0, 1'b0, 4'd0);
    for (int k = 1; k <= 20; k++) begin
      step();
      chk("t1.number", int'(num_a), (k - 1) % 16);
      chk("t1.wrap",   int'(wrap_a), (k == 17) ? 1 : 0);
    end

    // Down count through zero on the MAX 9 instance.
    do_reset();
    drive(1'b1, CNT_DOWN, 1'b0, 1'b0, 4'd0);
    for (int k = 1; k <= 13; k++) begin
      step();
      if (k == 2 || k == 12) begin
        chk("t2.number", int'(num_b), 9);
        chk("t2.wrap",   int'(wrap_b), 1);
      end
    end

    // Saturating up from a load of 13, then saturating down to 0.
    drive(1'b0, CNT_UP, 1'b1, 1'b1, 4'd13);
    step();
    drive(1'b1, CNT_UP, 1'b1, 1'b0, 4'd0);
    for (int k = 0; k < 6; k++) step();
    chk("t3.sat_hi", int'(num_a), 15);
    chk("t3.tc",     int'(tc_a), 1);
    chk("t3.nowrap", int'(wrap_a), 0);
    drive(1'b1, CNT_DOWN, 1'b1, 1'b0, 4'd0);
    for (int k = 0; k < 19; k++) step();
    chk("t3.sat_lo", int'(num_a), 0);
    chk("t3.zero",   int'(zero_a), 1);

    // Clamped load and load with counting disabled.
    drive(1'b1, CNT_UP, 1'b0, 1'b1, 4'd12);
    step();
    drive(1'b0, CNT_UP, 1'b0, 1'b0, 4'd0);
    step();
    chk("t4.clamp", int'(num_b), 9);
    drive(1'b0, CNT_DOWN, 1'b0, 1'b1, 4'd3);
    step();
    drive(1'b0, CNT_UP, 1'b1, 1'b0, 4'd0);
    step();
    step();
    chk("t4.load3", int'(num_b), 3);

    // Load at the terminal count wins over the wrap.
    drive(1'b1, CNT_UP, 1'b0, 1'b1, 4'd15);
    step();
    drive(1'b1, CNT_UP, 1'b0, 1'b1, 4'd5);
    step();
    chk("t5.at15", int'(num_a), 15);
    drive(1'b0, CNT_UP, 1'b0, 1'b0, 4'd0);
    step();
    chk("t5.num5",  int'(num_a), 5);
    chk("t5.nowrp", int'(wrap_a), 0);
    step();
    chk("t5.nowrp2", int'(wrap_a), 0);

    // Asynchronous reset between edges while counting at 7.
    drive(1'b0, CNT_UP, 1'b0, 1'b1, 4'd7);
    step();
    drive(1'b1, CNT_UP, 1'b0, 1'b0, 4'd0);
    step();
    chk("t6.at7", int'(num_a), 7);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("t6.rst_num",  int'(num_a), 0);
    chk("t6.rst_tc",   int'(tc_a), 0);
    chk("t6.rst_numb", int'(num_b), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("t6.zero_pre", int'(zero_a), 0);
    step();
    chk("t6.zero_post", int'(zero_a), 1);

    // Randomised traffic against the model.
    for (int k = 0; k < 400; k++) begin
      drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) == 0),
            4'($urandom_range(0, 15)));
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_mod_updown_counter
`default_nettype wire
